// File: rtl/memory_access.sv
// Memory-access stage: loads/stores on a valid/ready data bus,
// one-entry writeback buffer and bypass value.
module memory_access #(
  parameter int ADDR_WIDTH = 32,
  parameter int XLEN       = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [1:0]            s_op,
  input  logic [2:0]            s_size,
  input  logic [4:0]            s_rd,
  input  logic [XLEN-1:0]       s_alu,
  input  logic [XLEN-1:0]       s_rs2,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic                  dmem_we,
  output logic [3:0]            dmem_be,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_rsp_valid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [4:0]            m_rd,
  output logic [XLEN-1:0]       m_data,
  output logic                  m_wen,
  output logic                  m_trap,
  output logic [XLEN-1:0]       bypass
);

  localparam logic [1:0] OP_NULL  = 2'd0;
  localparam logic [1:0] OP_REG   = 2'd1;
  localparam logic [1:0] OP_LOAD  = 2'd2;
  localparam logic [1:0] OP_STORE = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e                state_q;
  logic                  req_valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [XLEN-1:0]       wdata_q;
  logic [2:0]            size_q;
  logic [1:0]            lane_q;
  logic [4:0]            rd_q;
  logic                  m_tvalid_q;
  logic [4:0]            m_rd_q;
  logic [XLEN-1:0]       m_data_q;
  logic                  m_wen_q;
  logic                  m_trap_q;

  logic            is_b, is_h, misal;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] rsh, load_c;
  logic            accept;

  assign s_tready = (state_q == IDLE) & (~m_tvalid_q | m_tready);
  assign accept   = s_tvalid & s_tready;

  // Reserved size codes fall through to word handling.
  always_comb begin
    is_b    = (s_size[1:0] == 2'b00);
    is_h    = (s_size[1:0] == 2'b01);
    misal   = (is_h & s_alu[0]) | (~is_b & ~is_h & (|s_alu[1:0]));
    be_c    = 4'b1111;
    wdata_c = s_rs2;
    if (is_b) begin
      be_c    = 4'b0001 << s_alu[1:0];
      wdata_c = {4{s_rs2[7:0]}};
    end else if (is_h) begin
      be_c    = 4'b0011 << s_alu[1:0];
      wdata_c = {2{s_rs2[15:0]}};
    end
  end

  always_comb begin
    rsh    = dmem_rdata >> {lane_q, 3'b000};
    load_c = rsh;
    unique case (size_q[1:0])
      2'b00:   load_c = {{(XLEN-8){rsh[7] & ~size_q[2]}}, rsh[7:0]};
      2'b01:   load_c = {{(XLEN-16){rsh[15] & ~size_q[2]}}, rsh[15:0]};
      default: load_c = rsh;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= 4'b0;
      wdata_q     <= '0;
      size_q      <= 3'b0;
      lane_q      <= 2'b0;
      rd_q        <= 5'b0;
      m_tvalid_q  <= 1'b0;
      m_rd_q      <= 5'b0;
      m_data_q    <= '0;
      m_wen_q     <= 1'b0;
      m_trap_q    <= 1'b0;
    end else begin
      if (m_tvalid_q && m_tready) m_tvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: if (accept) begin
          unique case (s_op)
            OP_NULL: ;
            OP_REG: begin
              m_tvalid_q <= 1'b1;
              m_rd_q     <= s_rd;
              m_data_q   <= s_alu;
              m_wen_q    <= |s_rd;
              m_trap_q   <= 1'b0;
            end
            OP_LOAD, OP_STORE: begin
              if (misal) begin
                m_tvalid_q <= 1'b1;
                m_rd_q     <= s_rd;
                m_data_q   <= s_alu;
                m_wen_q    <= 1'b0;
                m_trap_q   <= 1'b1;
              end else begin
                state_q     <= REQ;
                req_valid_q <= 1'b1;
                addr_q      <= {s_alu[ADDR_WIDTH-1:2], 2'b00};
                we_q        <= (s_op == OP_STORE);
                be_q        <= be_c;
                wdata_q     <= wdata_c;
                size_q      <= s_size;
                lane_q      <= s_alu[1:0];
                rd_q        <= s_rd;
              end
            end
            default: ;
          endcase
        end
        REQ: if (dmem_req_ready) begin
          req_valid_q <= 1'b0;
          state_q     <= we_q ? IDLE : WAIT;
        end
        WAIT: if (dmem_rsp_valid) begin
          m_tvalid_q <= 1'b1;
          m_rd_q     <= rd_q;
          m_data_q   <= load_c;
          m_wen_q    <= |rd_q;
          m_trap_q   <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req_valid = req_valid_q;
  assign dmem_addr      = addr_q;
  assign dmem_we        = we_q;
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;
  assign m_tvalid       = m_tvalid_q;
  assign m_rd           = m_rd_q;
  assign m_data         = m_data_q;
  assign m_wen          = m_wen_q;
  assign m_trap         = m_trap_q;
  assign bypass         = m_data_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: register stream, loads,
// stores, traps, backpressure and reset during a load.
module tb_memory_access;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_tvalid;
  logic        s_tready;
  logic [1:0]  s_op;
  logic [2:0]  s_size;
  logic [4:0]  s_rd;
  logic [31:0] s_alu;
  logic [31:0] s_rs2;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_wen;
  logic        m_trap;
  logic [31:0] bypass;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  memory_access dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_op(s_op), .s_size(s_size), .s_rd(s_rd),
    .s_alu(s_alu), .s_rs2(s_rs2),
    .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_rd(m_rd), .m_data(m_data), .m_wen(m_wen),
    .m_trap(m_trap), .bypass(bypass)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] sz,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] rs2);
    s_tvalid = 1'b1;
    s_op = op; s_size = sz; s_rd = rd;
    s_alu = alu; s_rs2 = rs2;
    chk("issue_tready", {31'b0, s_tready}, 32'd1);
    step();
    s_tvalid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] sz,
                         input logic [4:0] rd, input logic [31:0] a,
                         input int rwait, input logic [31:0] rdata,
                         input logic [31:0] exp, input logic wen);
    issue(2'd2, sz, rd, a, 32'h0);
    chk({tag, "_reqv"}, {31'b0, dmem_req_valid}, 32'd1);
    chk({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
    chk({tag, "_we"}, {31'b0, dmem_we}, 32'd0);
    for (int i = 0; i < rwait; i++) begin
      step();
      chk({tag, "_hold"}, {31'b0, dmem_req_valid}, 32'd1);
      chk({tag, "_haddr"}, dmem_addr, {a[31:2], 2'b00});
    end
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    chk({tag, "_reqdone"}, {31'b0, dmem_req_valid}, 32'd0);
    chk({tag, "_notyet"}, {31'b0, m_tvalid}, 32'd0);
    dmem_rsp_valid = 1'b1;
    dmem_rdata = rdata;
    step();
    dmem_rsp_valid = 1'b0;
    chk({tag, "_mv"}, {31'b0, m_tvalid}, 32'd1);
    chk({tag, "_data"}, m_data, exp);
    chk({tag, "_wen"}, {31'b0, m_wen}, {31'b0, wen});
    chk({tag, "_rd"}, {27'b0, m_rd}, {27'b0, rd});
    chk({tag, "_trap"}, {31'b0, m_trap}, 32'd0);
    step();
    chk({tag, "_drain"}, {31'b0, m_tvalid}, 32'd0);
  endtask

  initial begin
    aresetn = 1'b0;
    s_tvalid = 1'b0; s_op = 2'd0; s_size = 3'd0;
    s_rd = 5'd0; s_alu = 32'h0; s_rs2 = 32'h0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    dmem_rdata = 32'h0; m_tready = 1'b1;
    step();
    chk("rst_mv", {31'b0, m_tvalid}, 32'd0);
    chk("rst_wen", {31'b0, m_wen}, 32'd0);
    chk("rst_trap", {31'b0, m_trap}, 32'd0);
    chk("rst_data", m_data, 32'h0);
    chk("rst_reqv", {31'b0, dmem_req_valid}, 32'd0);
    chk("rst_be", {28'b0, dmem_be}, 32'd0);
    aresetn = 1'b1;
    step();

    // back-to-back register ops
    for (int i = 0; i < 4; i++) begin
      issue(2'd1, 3'd0, 5'(i + 1), 32'h10 + i, 32'h0);
      s_tvalid = 1'b1;
      chk("reg_mv", {31'b0, m_tvalid}, 32'd1);
      chk("reg_data", m_data, 32'h10 + i);
      chk("reg_rd", {27'b0, m_rd}, i + 1);
      chk("reg_wen", {31'b0, m_wen}, 32'd1);
      chk("reg_byp", bypass, 32'h10 + i);
    end
    s_tvalid = 1'b0;
    step();
    chk("reg_idle", {31'b0, m_tvalid}, 32'd0);

    // NULL op produces nothing
    issue(2'd0, 3'd0, 5'd3, 32'h55, 32'h0);
    chk("null_mv", {31'b0, m_tvalid}, 32'd0);

    // backpressure
    m_tready = 1'b0;
    issue(2'd1, 3'd0, 5'd5, 32'hAA, 32'h0);
    s_tvalid = 1'b1; s_op = 2'd1; s_rd = 5'd6; s_alu = 32'hBB;
    for (int i = 0; i < 5; i++) begin
      chk("bp_mv", {31'b0, m_tvalid}, 32'd1);
      chk("bp_data", m_data, 32'hAA);
      chk("bp_rd", {27'b0, m_rd}, 32'd5);
      chk("bp_tready", {31'b0, s_tready}, 32'd0);
      step();
    end
    m_tready = 1'b1;
    #1;
    chk("bp_rel", {31'b0, s_tready}, 32'd1);
    step();
    s_tvalid = 1'b0;
    chk("bp_next", m_data, 32'hBB);
    chk("bp_next_rd", {27'b0, m_rd}, 32'd6);
    step();
    chk("bp_drain", {31'b0, m_tvalid}, 32'd0);

    // loads: lane extraction and extension
    do_load("lb", 3'b000, 5'd7, 32'h1003, 2, 32'h80FF_0000,
            32'hFFFF_FF80, 1'b1);
    do_load("lbu", 3'b100, 5'd7, 32'h1003, 2, 32'h80FF_0000,
            32'h0000_0080, 1'b1);
    do_load("lh", 3'b001, 5'd8, 32'h1002, 0, 32'h80FF_0000,
            32'hFFFF_80FF, 1'b1);
    do_load("lhu", 3'b101, 5'd8, 32'h1002, 1, 32'h80FF_0000,
            32'h0000_80FF, 1'b1);
    do_load("lw0", 3'b010, 5'd0, 32'h1004, 0, 32'h1234_5678,
            32'h1234_5678, 1'b0);

    // stores
    issue(2'd3, 3'b001, 5'd4, 32'h2002, 32'h1234_ABCD);
    chk("sh_reqv", {31'b0, dmem_req_valid}, 32'd1);
    chk("sh_addr", dmem_addr, 32'h2000);
    chk("sh_we", {31'b0, dmem_we}, 32'd1);
    chk("sh_be", {28'b0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    chk("sh_done", {31'b0, dmem_req_valid}, 32'd0);
    chk("sh_mv", {31'b0, m_tvalid}, 32'd0);
    chk("sh_idle", {31'b0, s_tready}, 32'd1);
    issue(2'd3, 3'b000, 5'd4, 32'h2001, 32'h0000_00EF);
    chk("sb_be", {28'b0, dmem_be}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hEFEF_EFEF);
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    chk("sb_mv", {31'b0, m_tvalid}, 32'd0);

    // misaligned word load traps
    issue(2'd2, 3'b010, 5'd9, 32'h3001, 32'h0);
    chk("mis_reqv", {31'b0, dmem_req_valid}, 32'd0);
    chk("mis_mv", {31'b0, m_tvalid}, 32'd1);
    chk("mis_trap", {31'b0, m_trap}, 32'd1);
    chk("mis_wen", {31'b0, m_wen}, 32'd0);
    chk("mis_data", m_data, 32'h3001);
    step();
    chk("mis_drain", {31'b0, m_tvalid}, 32'd0);

    // reset while waiting for a load response
    issue(2'd2, 3'b010, 5'd3, 32'h4000, 32'h0);
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("ar_mv", {31'b0, m_tvalid}, 32'd0);
    chk("ar_data", m_data, 32'h0);
    chk("ar_trap", {31'b0, m_trap}, 32'd0);
    chk("ar_reqv", {31'b0, dmem_req_valid}, 32'd0);
    step();
    aresetn = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_rsp_valid = 1'b0;
    chk("ar_late", {31'b0, m_tvalid}, 32'd0);
    step();
    chk("ar_late2", {31'b0, m_tvalid}, 32'd0);
    chk("ar_tready", {31'b0, s_tready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
